debounce_sync: RTL and testbench

Input-conditioning stage that sits directly upstream of the async-clear D flip-flops in the unisim library. It synchronizes a raw asynchronous level `D` into clock domain `C` with a two-flop synchronizer. It then debounces the level with a consecutive-sample counter. It outputs a clean registered level `Q`, which drives a downstream flop's `D`, plus single-cycle `RISE`/`FALL` strobes.

---
 rtl/debounce_sync.sv | 101 ++++++++++
 tb/tb_debounce_sync.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchronizer followed by a consecutive-sample
// debouncer. Produces a registered clean level Q plus one-cycle RISE/FALL
// strobes. STABLE_CYCLES must lie in 1 .. 2**CNT_WIDTH-1.
module debounce_sync #(
  parameter logic INIT          = 1'b0,
  parameter int   STABLE_CYCLES = 8,
  parameter int   CNT_WIDTH     = 4
) (
  input  logic C,
  input  logic CLR,
  input  logic D,
  output logic Q,
  output logic RISE,
  output logic FALL,
  output logic BUSY
);

  typedef enum logic {IDLE = 1'b0, CHECK = 1'b1} state_t;

  // Counter compare is done one bit wider so cnt+1 can never alias to zero.
  localparam logic [CNT_WIDTH:0] LIMIT  = (CNT_WIDTH+1)'(STABLE_CYCLES);
  localparam logic [CNT_WIDTH:0] ONE_W  = (CNT_WIDTH+1)'(1);
  localparam bit                 SINGLE = (STABLE_CYCLES == 1);

  logic                 s1;
  logic                 s2;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt} + ONE_W;

  // Busy reflects only the state register, so it carries no glitches from s2.
  assign BUSY = (state == CHECK);

  // Two-flop synchronizer; any metastability is confined to s1.
  always_ff @(posedge C or negedge CLR) begin
    if (!CLR) begin
      s1 <= INIT;
      s2 <= INIT;
    end else begin
      s1 <= D;
      s2 <= s1;
    end
  end

  // Debounce FSM: count consecutive samples where s2 differs from Q and
  // commit the new level once the run reaches STABLE_CYCLES.
  always_ff @(posedge C or negedge CLR) begin
    if (!CLR) begin
      state <= IDLE;
      cnt   <= '0;
      Q     <= INIT;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared unless a commit below sets them.
      RISE <= 1'b0;
      FALL <= 1'b0;
      case (state)
        IDLE: begin
          if (s2 != Q) begin
            if (SINGLE) begin
              // One differing sample is enough: commit immediately.
              Q     <= s2;
              RISE  <= s2;
              FALL  <= ~s2;
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt   <= CNT_WIDTH'(1);
              state <= CHECK;
            end
          end else begin
            cnt <= '0;
          end
        end
        CHECK: begin
          if (s2 == Q) begin
            // Bounce ended before qualifying: drop the candidate silently.
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt_inc == LIMIT) begin
            Q     <= s2;
            RISE  <= s2;
            FALL  <= ~s2;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt_inc[CNT_WIDTH-1:0];
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: table-driven cycle vectors with a scoreboard queue for
// debounce_sync (STABLE_CYCLES=8) plus a single-cycle-qualification instance.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic clr_n;
  logic d;
  logic d1;
  logic q, rise, fall, busy;
  logic q1, rise1, fall1, busy1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic d;
    logic q;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  vec_t vec [0:63];
  vec_t sb [$];

  always #5 clk = ~clk;

  debounce_sync #(.INIT(1'b0), .STABLE_CYCLES(8), .CNT_WIDTH(4)) dut (
    .C(clk), .CLR(clr_n), .D(d), .Q(q), .RISE(rise), .FALL(fall), .BUSY(busy)
  );

  debounce_sync #(.INIT(1'b0), .STABLE_CYCLES(1), .CNT_WIDTH(1)) dut1 (
    .C(clk), .CLR(clr_n), .D(d1), .Q(q1), .RISE(rise1), .FALL(fall1), .BUSY(busy1)
  );

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  task automatic check_bit(input string name, input int idx, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s @%0d: got %b expected %b", name, idx, act, want);
    end
  endtask

  task automatic check_int(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  // Pop the oldest expectation and compare it against the given outputs.
  task automatic pop_compare(input string tag, input int idx, input logic aq,
                             input logic ar, input logic af, input logic ab);
    vec_t want;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s @%0d: scoreboard empty", tag, idx);
    end else begin
      want = sb.pop_front();
      check_bit({tag, ".Q"}, idx, aq, want.q);
      check_bit({tag, ".RISE"}, idx, ar, want.rise);
      check_bit({tag, ".FALL"}, idx, af, want.fall);
      check_bit({tag, ".BUSY"}, idx, ab, want.busy);
      $display("%s edge %0d: D=%b Q=%b RISE=%b FALL=%b BUSY=%b", tag, idx,
               want.d, aq, ar, af, ab);
    end
  endtask

  // Drive D before the next edge, then compare just after it (on negedge).
  task automatic step_main(input string tag, input int idx, input vec_t v);
    d = v.d;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    pop_compare(tag, idx, q, rise, fall, busy);
  endtask

  task automatic step_one(input string tag, input int idx, input vec_t v);
    d1 = v.d;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    pop_compare(tag, idx, q1, rise1, fall1, busy1);
  endtask

  task automatic run_table(input string tag, input int n);
    for (int e = 1; e <= n; e++) step_main(tag, e, vec[e]);
  endtask

  // Release between edges; the following edge is edge 1 of the next run.
  task automatic release_reset();
    @(posedge clk);
    #1 clr_n = 1'b1;
    @(negedge clk);
  endtask

  // Hold reset across edges with D at dlev and check reset state of both DUTs.
  task automatic do_reset(input string tag, input logic dlev);
    vec_t z;
    @(negedge clk);
    clr_n = 1'b0;
    d     = dlev;
    d1    = 1'b0;
    z = '{dlev, 1'b0, 1'b0, 1'b0, 1'b0};
    #1;
    sb.push_back(z);
    pop_compare({tag, ".rst"}, 0, q, rise, fall, busy);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    sb.push_back(z);
    pop_compare({tag, ".rst_hold"}, 0, q, rise, fall, busy);
    sb.push_back(z);
    pop_compare({tag, ".rst_one"}, 0, q1, rise1, fall1, busy1);
    release_reset();
  endtask

  // Assert reset between clock edges and expect outputs to clear at once.
  task automatic async_reset_check(input string tag);
    vec_t z;
    #2 clr_n = 1'b0;
    #1;
    z = '{d, 1'b0, 1'b0, 1'b0, 1'b0};
    sb.push_back(z);
    pop_compare(tag, 0, q, rise, fall, busy);
  endtask

  initial begin
    vec_t v;
    clr_n = 1'b0;
    d     = 1'b0;
    d1    = 1'b0;

    // Reset with D held high: Q at release edge +10, one RISE, no FALL.
    do_reset("rst_dhigh", 1'b1);
    for (int e = 1; e <= 14; e++) begin
      v = '{1'b1, (e >= 10), (e == 10), 1'b0, (e >= 3 && e <= 9)};
      step_main("rst_dhigh", e, v);
    end
    async_reset_check("async_q1");

    // Clean step up at edge 5, down at edge 30.
    do_reset("clean", 1'b0);
    for (int e = 1; e <= 45; e++) begin
      vec[e].d    = (e >= 5 && e < 30);
      vec[e].q    = (e >= 14 && e < 39);
      vec[e].rise = (e == 14);
      vec[e].fall = (e == 39);
      vec[e].busy = (e >= 7 && e <= 13) || (e >= 32 && e <= 38);
    end
    run_table("clean", 45);

    // Five-cycle glitch: counted for five cycles, then dropped.
    do_reset("glitch", 1'b0);
    for (int e = 1; e <= 20; e++) begin
      vec[e].d    = (e >= 5 && e <= 9);
      vec[e].q    = 1'b0;
      vec[e].rise = 1'b0;
      vec[e].fall = 1'b0;
      vec[e].busy = (e >= 7 && e <= 11);
    end
    run_table("glitch", 20);
    check_int("glitch.cnt", int'(dut.cnt), 0);

    // Bounce train: three 2-cycle high pulses, then steady high from edge 13.
    do_reset("bounce", 1'b0);
    for (int e = 1; e <= 30; e++) begin
      vec[e].d    = (e == 5 || e == 6 || e == 9 || e == 10 || e >= 13);
      vec[e].q    = (e >= 22);
      vec[e].rise = (e == 22);
      vec[e].fall = 1'b0;
      vec[e].busy = (e == 7 || e == 8 || e == 11 || e == 12) || (e >= 15 && e <= 21);
    end
    run_table("bounce", 30);
    async_reset_check("async_bounce");

    // Reset at cnt=5 mid-count with D still high; full requalification after.
    do_reset("midcnt", 1'b0);
    for (int e = 1; e <= 7; e++) begin
      v = '{1'b1, 1'b0, 1'b0, 1'b0, (e >= 3)};
      step_main("midcnt", e, v);
    end
    check_int("midcnt.cnt_before", int'(dut.cnt), 5);
    async_reset_check("midcnt.async");
    check_int("midcnt.cnt_reset", int'(dut.cnt), 0);
    release_reset();
    for (int e = 1; e <= 12; e++) begin
      v = '{1'b1, (e >= 10), (e == 10), 1'b0, (e >= 3 && e <= 9)};
      step_main("midcnt_rel", e, v);
    end

    // STABLE_CYCLES=1: commit two edges after the D step, BUSY never high.
    do_reset("single", 1'b0);
    for (int e = 1; e <= 16; e++) begin
      v = '{(e >= 3 && e <= 10), (e >= 5 && e < 13), (e == 5), (e == 13), 1'b0};
      step_one("single", e, v);
    end

    check_int("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
